mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage (EX/MEM register plus data memory) and the register-file/CSR writeback.
- Latches the MEM result on a valid/allowin handshake and aligns, masks and sign-extends load data.
- Selects the writeback source and drives GPR/CSR commit and a forwarding port.
- Keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 64, datapath width
PC_W, 32, PC width

Ports:
I_sys_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_MEM_WB_valid  in  1  upstream result valid; EX/MEM O_EX_MEM_valid
O_MEM_WB_allowin  out  1  to EX/MEM allowout
I_MEM_WB_allowout  in  1  commit side ready; tie 1 if unused
O_MEM_WB_valid  out  1  stage holds a committable instruction
I_rstrb  in  9  [7:0] byte mask 01/03/0F/FF; [8]=1 sign-extend
I_alu_out  in  XLEN  ALU result; [2:0] = load byte offset
I_mem_rdata  in  XLEN  aligned doubleword; valid with I_MEM_WB_valid on loads
I_regin_sel  in  2  00 ALU, 01 CSR old value, 1x load
I_pc  in  PC_W  instruction PC
I_reg_wen  in  1  GPR write
I_rd_addr  in  5  destination
I_csr_addr, I_csr_wen, I_csr_intr, I_csr_intr_no, I_csr_mret, I_csr, I_fencei  in  12/1/1/64/1/64/1  CSR side-band
O_reg_wen  out  1  GPR write strobe
O_rd_addr  out  5  GPR index
O_wb_data  out  XLEN  GPR write data
O_fwd_valid  out  1  forwarding hit qualifier
O_csr_addr, O_csr_wen, O_csr_intr, O_csr_intr_no, O_csr_mret, O_csr, O_fencei  out  same widths  gated CSR commit
O_pc  out  PC_W  committing PC
O_instret  out  64  retired count

Behaviour:
Handshake and holding:
- O_MEM_WB_allowin = !valid_q || I_MEM_WB_allowout.
- valid_q loads I_MEM_WB_valid when allowin, else holds.
- Payload loads only on I_MEM_WB_valid && O_MEM_WB_allowin, else holds.
- O_MEM_WB_valid = valid_q.
- Latency: exactly 1 cycle from the accept edge.
- Back-to-back accepts with no bubble when allowout=1.

Load formatting (combinational on the latched data, computed before the register):
- sh = I_mem_rdata >> (8*I_alu_out[2:0]).
- Mask by I_rstrb[7:0]; if I_rstrb[8], sign-extend from the top byte of the mask.
- Masks other than the four legal ones are treated as FF.
- Misaligned accesses are not handled: the result is the shifted value, and the upper bytes are zero-filled by the shift.

Writeback source:
- 00 → ALU result; 01 → I_csr; 1x → formatted load.
- Stored as wb_data_q.

Commit strobes:
- O_reg_wen = valid_q & reg_wen_q & (rd_q!=0) & I_MEM_WB_allowout.
- O_fwd_valid = valid_q & reg_wen_q & (rd_q!=0), independent of allowout.
- O_csr_wen, O_csr_intr, O_csr_mret, O_fencei are the latched value ANDed with valid_q & I_MEM_WB_allowout. The remaining CSR outputs are the raw latched values.
- Each strobe is high for exactly one cycle per instruction.

Retire counter:
- O_instret increments by 1 on valid_q && I_MEM_WB_allowout.
- Wraps at 2^64-1 → 0.

Reset:
- All outputs and internal registers go to 0; O_MEM_WB_allowin = 1 the cycle after reset.
- Reset mid-stall drops the held instruction: no strobe fires.

Simultaneous events:
- Retire and accept in the same cycle: the old instruction commits, the new one is latched, and the counter still increments.

Optional Feature:
YSYX_040750_COMMIT_TRACE_EN
- Enabled adds outputs:
  - O_commit_pc (PC_W): latched PC.
  - O_commit_pulse (1): valid_q & I_MEM_WB_allowout.
  - O_commit_wdata (XLEN): wb_data_q.
- These feed difftest.
- Disabled: the ports are absent and there is no extra logic.

Decomposition:
- Shared package holds:
  - REGIN_ALU=2'b00, REGIN_CSR=2'b01, REGIN_MEM bit index 1.
  - RSTRB_B/H/W/D mask constants and the RSTRB_SEXT bit index 8.
  - XLEN.
- One natural sub-module: load_align (pure combinational shift/mask/extend), reusable by a future data-cache bypass.

Test Plan:
1. lb: rdata=0x80FF_0000_0000_0000, alu_out[2:0]=7, rstrb=0x101 → wb_data=0xFFFF_FFFF_FFFF_FF80; one cycle later O_reg_wen=1.
2. lhu: rdata=0x0000_0000_8001_0000, offset 2, rstrb=0x003 → wb_data=0x0000_0000_0000_8001.
3. Stall: three back-to-back valids with allowout held 0 for 2 cycles after the first → allowin=0; the second instruction is held; after release, commits occur in order with no duplicate O_reg_wen; O_instret=3.
4. rd=0 with reg_wen=1 → O_reg_wen and O_fwd_valid stay 0; instret still counts.
5. CSR instruction (regin_sel=01, I_csr=0x1234, csr_wen=1) → wb_data=0x1234 and O_csr_wen is a single-cycle pulse.
6. Assert I_rst while an instruction is held under stall → no commit strobe; all outputs 0; allowin=1 next cycle.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB pipeline register: writeback source
// encodings, load byte-mask strobes and the default datapath width.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] REGIN_ALU = 2'b00;
  localparam logic [1:0] REGIN_CSR = 2'b01;
  localparam int unsigned REGIN_MEM = 1;

  localparam logic [7:0] RSTRB_B = 8'h01;
  localparam logic [7:0] RSTRB_H = 8'h03;
  localparam logic [7:0] RSTRB_W = 8'h0F;
  localparam logic [7:0] RSTRB_D = 8'hFF;
  localparam int unsigned RSTRB_SEXT = 8;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Pure combinational load formatter: shift the doubleword down by the byte
// offset, keep the bytes named by the strobe and optionally sign-extend.
module mem_wb_stage_load_align #(
  parameter int unsigned XLEN = mem_wb_stage_pkg::XLEN
) (
  input  logic [XLEN-1:0] I_rdata,
  input  logic [2:0]      I_offset,
  input  logic [8:0]      I_rstrb,
  output logic [XLEN-1:0] O_data
);
  import mem_wb_stage_pkg::*;

  logic [XLEN-1:0] sh;
  logic            sext;

  assign sh   = I_rdata >> {I_offset, 3'b000};
  assign sext = I_rstrb[RSTRB_SEXT];

  // Unrecognised masks fall through to the full doubleword.
  always_comb begin
    O_data = sh;
    case (I_rstrb[7:0])
      RSTRB_B: O_data = {{(XLEN-8){sext & sh[7]}},   sh[7:0]};
      RSTRB_H: O_data = {{(XLEN-16){sext & sh[15]}}, sh[15:0]};
      RSTRB_W: O_data = {{(XLEN-32){sext & sh[31]}}, sh[31:0]};
      default: O_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: valid/allowin handshake, writeback source select,
// gated GPR/CSR commit, forwarding qualifier and retired-instruction counter.
// Optional commit trace ports are enabled by YSYX_040750_COMMIT_TRACE_EN.
module mem_wb_stage #(
  parameter int unsigned XLEN = mem_wb_stage_pkg::XLEN,
  parameter int unsigned PC_W = 32
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_MEM_WB_valid,
  output logic            O_MEM_WB_allowin,
  input  logic            I_MEM_WB_allowout,
  output logic            O_MEM_WB_valid,
  input  logic [8:0]      I_rstrb,
  input  logic [XLEN-1:0] I_alu_out,
  input  logic [XLEN-1:0] I_mem_rdata,
  input  logic [1:0]      I_regin_sel,
  input  logic [PC_W-1:0] I_pc,
  input  logic            I_reg_wen,
  input  logic [4:0]      I_rd_addr,
  input  logic [11:0]     I_csr_addr,
  input  logic            I_csr_wen,
  input  logic            I_csr_intr,
  input  logic [63:0]     I_csr_intr_no,
  input  logic            I_csr_mret,
  input  logic [63:0]     I_csr,
  input  logic            I_fencei,
  output logic            O_reg_wen,
  output logic [4:0]      O_rd_addr,
  output logic [XLEN-1:0] O_wb_data,
  output logic            O_fwd_valid,
  output logic [11:0]     O_csr_addr,
  output logic            O_csr_wen,
  output logic            O_csr_intr,
  output logic [63:0]     O_csr_intr_no,
  output logic            O_csr_mret,
  output logic [63:0]     O_csr,
  output logic            O_fencei,
  output logic [PC_W-1:0] O_pc,
  output logic [63:0]     O_instret
`ifdef YSYX_040750_COMMIT_TRACE_EN
  ,
  output logic [PC_W-1:0] O_commit_pc,
  output logic            O_commit_pulse,
  output logic [XLEN-1:0] O_commit_wdata
`endif
);
  import mem_wb_stage_pkg::*;

  logic            valid_q;
  logic            accept;
  logic            retire;
  logic            rd_nz;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_next;

  logic [XLEN-1:0] wb_data_q;
  logic [PC_W-1:0] pc_q;
  logic            reg_wen_q;
  logic [4:0]      rd_q;
  logic [11:0]     csr_addr_q;
  logic            csr_wen_q;
  logic            csr_intr_q;
  logic [63:0]     csr_intr_no_q;
  logic            csr_mret_q;
  logic [63:0]     csr_q;
  logic            fencei_q;
  logic [63:0]     instret_q;

  assign O_MEM_WB_allowin = !valid_q || I_MEM_WB_allowout;
  assign accept           = I_MEM_WB_valid && O_MEM_WB_allowin;
  assign retire           = valid_q && I_MEM_WB_allowout;

  mem_wb_stage_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .I_rdata (I_mem_rdata),
    .I_offset(I_alu_out[2:0]),
    .I_rstrb (I_rstrb),
    .O_data  (load_data)
  );

  always_comb begin
    wb_next = I_alu_out;
    if (I_regin_sel[REGIN_MEM])
      wb_next = load_data;
    else if (I_regin_sel == REGIN_CSR)
      wb_next = XLEN'(I_csr);
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst)
      valid_q <= 1'b0;
    else if (O_MEM_WB_allowin)
      valid_q <= I_MEM_WB_valid;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      wb_data_q     <= '0;
      pc_q          <= '0;
      reg_wen_q     <= 1'b0;
      rd_q          <= '0;
      csr_addr_q    <= '0;
      csr_wen_q     <= 1'b0;
      csr_intr_q    <= 1'b0;
      csr_intr_no_q <= '0;
      csr_mret_q    <= 1'b0;
      csr_q         <= '0;
      fencei_q      <= 1'b0;
    end else if (accept) begin
      wb_data_q     <= wb_next;
      pc_q          <= I_pc;
      reg_wen_q     <= I_reg_wen;
      rd_q          <= I_rd_addr;
      csr_addr_q    <= I_csr_addr;
      csr_wen_q     <= I_csr_wen;
      csr_intr_q    <= I_csr_intr;
      csr_intr_no_q <= I_csr_intr_no;
      csr_mret_q    <= I_csr_mret;
      csr_q         <= I_csr;
      fencei_q      <= I_fencei;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst)
      instret_q <= '0;
    else if (retire)
      instret_q <= instret_q + 64'd1;
  end

  assign rd_nz          = (rd_q != 5'd0);
  assign O_MEM_WB_valid = valid_q;
  assign O_fwd_valid    = valid_q & reg_wen_q & rd_nz;
  assign O_reg_wen      = O_fwd_valid & I_MEM_WB_allowout;
  assign O_rd_addr      = rd_q;
  assign O_wb_data      = wb_data_q;
  assign O_pc           = pc_q;
  assign O_csr_addr     = csr_addr_q;
  assign O_csr_wen      = csr_wen_q & retire;
  assign O_csr_intr     = csr_intr_q & retire;
  assign O_csr_intr_no  = csr_intr_no_q;
  assign O_csr_mret     = csr_mret_q & retire;
  assign O_csr          = csr_q;
  assign O_fencei       = fencei_q & retire;
  assign O_instret      = instret_q;

`ifdef YSYX_040750_COMMIT_TRACE_EN
  assign O_commit_pc    = pc_q;
  assign O_commit_pulse = retire;
  assign O_commit_wdata = wb_data_q;
`endif

endmodule
